// File: rtl/matrix_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// matrix_pkg : shared widths, SPI command codes and FSM state types
// Rev 1.0
// ---------------------------------------------------------------------------
package matrix_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_RGB_W  = 3;

  localparam logic [7:0] CMD_FRAME = 8'h01;
  localparam logic [7:0] CMD_SEEK  = 8'h02;

  typedef enum logic [2:0] {
    P_IDLE = 3'd0,
    P_CMD  = 3'd1,
    P_AHI  = 3'd2,
    P_ALO  = 3'd3,
    P_PIX  = 3'd4,
    P_DROP = 3'd5
  } proto_state_t;

  typedef enum logic [1:0] {
    WR_IDLE   = 2'd0,
    WR_SETUP  = 2'd1,
    WR_STROBE = 2'd2,
    WR_HOLD   = 2'd3
  } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_byte_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_byte_rx : mode-0 SPI slave byte receiver with input synchronisers
// Rev 1.0
// ---------------------------------------------------------------------------
module spi_byte_rx #(
  parameter int SYNC_LEN = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs_n,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       cs_fall,
  output logic       cs_high
);

  logic [SYNC_LEN-1:0] r_sclk_sync;
  logic [SYNC_LEN-1:0] r_mosi_sync;
  logic [SYNC_LEN-1:0] r_cs_sync;
  logic                r_sclk_d;
  logic                r_cs_d;
  logic [2:0]          r_bit_cnt;
  logic [6:0]          r_shift;

  logic w_sclk;
  logic w_mosi;
  logic w_cs;
  logic w_sclk_rise;

  // SYNC_LEN must be at least 2; all three lines share the same latency
  assign w_sclk      = r_sclk_sync[SYNC_LEN-1];
  assign w_mosi      = r_mosi_sync[SYNC_LEN-1];
  assign w_cs        = r_cs_sync[SYNC_LEN-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign cs_fall     = r_cs_d & ~w_cs;
  assign cs_high     = w_cs;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 7'd0;
      byte_valid  <= 1'b0;
      byte_data   <= 8'd0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_LEN-2:0], sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_LEN-2:0], mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_LEN-2:0], cs_n};
      r_sclk_d    <= w_sclk;
      r_cs_d      <= w_cs;
      byte_valid  <= 1'b0;
      // Count held at zero while deselected, which also drops a partial byte
      if (w_cs) begin
        r_bit_cnt <= 3'd0;
      end else if (w_sclk_rise) begin
        r_shift   <= {r_shift[5:0], w_mosi};
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          byte_valid <= 1'b1;
          byte_data  <= {r_shift, w_mosi};
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_frame_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_frame_loader : SPI command decoder feeding the LED-matrix frame buffer
// Rev 1.0
// ---------------------------------------------------------------------------
module spi_frame_loader
  import matrix_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int RGB_W    = DEF_RGB_W,
  parameter int SYNC_LEN = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs_n,
  output logic              we,
  output logic [ADDR_W-1:0] adr_in,
  output logic [RGB_W-1:0]  rgb_in,
  output logic              frame_done,
  output logic              err
);

  logic       w_byte_valid;
  logic [7:0] w_byte;
  logic       w_cs_fall;
  logic       w_cs_high;

  proto_state_t      r_proto;
  wr_state_t         r_wr;
  logic [ADDR_W-1:0] r_ptr;
  logic [RGB_W-1:0]  r_pix_b;
  logic              r_second;

  spi_byte_rx #(.SYNC_LEN(SYNC_LEN)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .mosi      (mosi),
    .cs_n      (cs_n),
    .byte_valid(w_byte_valid),
    .byte_data (w_byte),
    .cs_fall   (w_cs_fall),
    .cs_high   (w_cs_high)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_proto    <= P_IDLE;
      r_wr       <= WR_IDLE;
      r_ptr      <= '0;
      r_pix_b    <= '0;
      r_second   <= 1'b0;
      we         <= 1'b0;
      adr_in     <= '0;
      rgb_in     <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      err        <= 1'b0;
      frame_done <= 1'b0;

      // A byte always wins over a same-cycle deselect; the idle return follows next cycle
      if (w_byte_valid && r_wr != WR_IDLE) begin
        err <= 1'b1;
      end else if (w_byte_valid) begin
        case (r_proto)
          P_CMD: begin
            if (w_byte == CMD_FRAME) begin
              r_ptr   <= '0;
              r_proto <= P_PIX;
            end else if (w_byte == CMD_SEEK) begin
              r_proto <= P_AHI;
            end else begin
              err     <= 1'b1;
              r_proto <= P_DROP;
            end
          end
          P_AHI: begin
            r_ptr[ADDR_W-1:8] <= w_byte[ADDR_W-9:0];
            r_proto           <= P_ALO;
          end
          P_ALO: begin
            r_ptr[7:0] <= w_byte;
            r_proto    <= P_PIX;
          end
          P_PIX: begin
            adr_in   <= r_ptr;
            rgb_in   <= RGB_W'(w_byte[6:4]);
            r_pix_b  <= RGB_W'(w_byte[2:0]);
            r_second <= 1'b0;
            r_wr     <= WR_SETUP;
          end
          default: ;
        endcase
      end else if (w_cs_fall) begin
        r_proto <= P_CMD;
      end else if (w_cs_high) begin
        r_proto <= P_IDLE;
      end

      // Address/data land on entry to SETUP so they lead the we rise by one clk
      case (r_wr)
        WR_SETUP: begin
          we   <= 1'b1;
          r_wr <= WR_STROBE;
        end
        WR_STROBE: begin
          we         <= 1'b0;
          r_ptr      <= r_ptr + 1'b1;
          frame_done <= &adr_in;
          r_wr       <= WR_HOLD;
        end
        WR_HOLD: begin
          if (!r_second) begin
            adr_in   <= r_ptr;
            rgb_in   <= r_pix_b;
            r_second <= 1'b1;
            r_wr     <= WR_SETUP;
          end else begin
            r_wr <= WR_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_spi_frame_loader : directed SPI transactions against a write-list model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_spi_frame_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       cs_n = 1'b1;
  logic       we;
  logic [9:0] adr_in;
  logic [2:0] rgb_in;
  logic       frame_done;
  logic       err;

  always #5 clk = ~clk;

  spi_frame_loader dut (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .mosi      (mosi),
    .cs_n      (cs_n),
    .we        (we),
    .adr_in    (adr_in),
    .rgb_in    (rgb_in),
    .frame_done(frame_done),
    .err       (err)
  );

  typedef struct packed {
    logic [9:0] adr;
    logic [2:0] rgb;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  we_seen = 0;
  int  fd_seen = 0;
  int  err_seen = 0;
  int  err_exp = 0;

  logic       prev_we = 1'b0;
  logic [9:0] prev_adr = '0;
  logic [2:0] prev_rgb = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Expected frame-buffer writes for one complete chip-select transaction
  task automatic model_xfer(input logic [7:0] bytes[$]);
    int p;
    int first;
    if (bytes.size() == 0) return;
    if (bytes[0] == 8'h01) begin
      p = 0;
      first = 1;
    end else if (bytes[0] == 8'h02) begin
      if (bytes.size() < 3) return;
      p = bytes[1][1:0] * 256 + bytes[2];
      first = 3;
    end else begin
      err_exp++;
      return;
    end
    for (int k = first; k < bytes.size(); k++) begin
      exp_q.push_back('{adr: 10'(p), rgb: bytes[k][6:4]});
      p = (p + 1) % 1024;
      exp_q.push_back('{adr: 10'(p), rgb: bytes[k][2:0]});
      p = (p + 1) % 1024;
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (!reset) begin
      if (we) begin
        we_seen++;
        check("we_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wr_adr", adr_in, e.adr);
          check("wr_rgb", rgb_in, e.rgb);
        end
        check("setup_adr", adr_in, prev_adr);
        check("setup_rgb", rgb_in, prev_rgb);
        check("we_width", prev_we, 0);
      end
      if (prev_we) begin
        check("hold_we", we, 0);
        check("hold_adr", adr_in, prev_adr);
        check("hold_rgb", rgb_in, prev_rgb);
        check("hold_frame_done", frame_done, prev_adr == 10'h3FF);
      end else begin
        check("frame_done_spurious", frame_done, 0);
      end
      if (frame_done) fd_seen++;
      if (err) err_seen++;
    end
    prev_we  = we;
    prev_adr = adr_in;
    prev_rgb = rgb_in;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_byte(input logic [7:0] b, input int nbits);
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = b[i];
      wait_clk(8);
      sclk = 1'b1;
      wait_clk(8);
      sclk = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] bytes[$], input int partial_bits);
    cs_n = 1'b0;
    wait_clk(8);
    foreach (bytes[i]) spi_byte(bytes[i], 8);
    if (partial_bits > 0) spi_byte(8'hAA, partial_bits);
    wait_clk(8);
    cs_n = 1'b1;
    wait_clk(16);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] q[$];
    int we0, fd0, err0;

    // 1: reset with random SPI activity
    for (int i = 0; i < 3; i++) begin
      sclk = 1'($urandom_range(0, 1));
      mosi = 1'($urandom_range(0, 1));
      cs_n = 1'($urandom_range(0, 1));
      wait_clk(1);
      check("rst_we", we, 0);
      check("rst_adr", adr_in, 0);
      check("rst_rgb", rgb_in, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_err", err, 0);
    end
    sclk = 1'b0;
    mosi = 1'b0;
    cs_n = 1'b1;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(8);

    // 2: full frame of 0x12
    we0 = we_seen; fd0 = fd_seen; err0 = err_seen;
    q = '{8'h01};
    for (int i = 0; i < 512; i++) q.push_back(8'h12);
    model_xfer(q);
    check("pin_frame_size", exp_q.size(), 1024);
    check("pin_frame_last_adr", exp_q[1023].adr, 10'd1023);
    check("pin_frame_rgb1", exp_q[1].rgb, 3'd2);
    xfer(q, 0);
    drain("frame_drain");
    check("frame_we_count", we_seen - we0, 1024);
    check("frame_done_count", fd_seen - fd0, 1);
    check("frame_err_count", err_seen - err0, 0);

    // 3: seek to 1023 and wrap
    we0 = we_seen; fd0 = fd_seen;
    q = '{8'h02, 8'h03, 8'hFF, 8'h51};
    model_xfer(q);
    check("pin_seek_adr0", exp_q[0].adr, 10'd1023);
    check("pin_seek_rgb0", exp_q[0].rgb, 3'd5);
    check("pin_seek_adr1", exp_q[1].adr, 10'd0);
    check("pin_seek_rgb1", exp_q[1].rgb, 3'd1);
    xfer(q, 0);
    drain("seek_drain");
    check("seek_we_count", we_seen - we0, 2);
    check("seek_frame_done_count", fd_seen - fd0, 1);

    // 4: unknown command
    we0 = we_seen; err0 = err_seen;
    q = '{8'h7F, 8'h11, 8'h22};
    model_xfer(q);
    xfer(q, 0);
    drain("badcmd_drain");
    check("badcmd_err_count", err_seen - err0, 1);
    check("badcmd_err_model", err_seen, err_exp);
    check("badcmd_we_count", we_seen - we0, 0);

    // 5: abort mid-byte, then restart
    we0 = we_seen;
    q = '{8'h01, 8'h33};
    model_xfer(q);
    check("pin_abort_adr1", exp_q[1].adr, 10'd1);
    check("pin_abort_rgb1", exp_q[1].rgb, 3'd3);
    xfer(q, 5);
    drain("abort_drain");
    check("abort_we_count", we_seen - we0, 2);
    q = '{8'h01, 8'h45};
    model_xfer(q);
    xfer(q, 0);
    drain("restart_drain");
    check("restart_we_count", we_seen - we0, 4);

    // 6: reset during the strobe of the first pixel
    we0 = we_seen;
    exp_q.push_back('{adr: 10'd0, rgb: 3'd7});
    cs_n = 1'b0;
    wait_clk(8);
    fork
      begin
        spi_byte(8'h01, 8);
        spi_byte(8'h77, 8);
      end
      begin
        int k;
        for (k = 0; k < 400 && !we; k++) @(negedge clk);
        check("midwr_strobe_seen", we, 1);
        #2 reset = 1'b1;
        @(negedge clk);
        check("midwr_we_low", we, 0);
        check("midwr_adr_clr", adr_in, 0);
      end
    join
    cs_n = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(40);
    check("midwr_we_count", we_seen - we0, 1);
    drain("midwr_drain");
    we0 = we_seen;
    q = '{8'h02, 8'h01, 8'h00, 8'h65};
    model_xfer(q);
    check("pin_seek100_adr", exp_q[0].adr, 10'h100);
    xfer(q, 0);
    drain("seek100_drain");
    check("seek100_we_count", we_seen - we0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got running, required finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
